cl_mem_responder: RTL

CL_MEM_RESPONDER -- requirements
Module: cl_mem_responder

---
 rtl/cl_mem_pkg.sv | 38 +++
 rtl/cl_req_fifo.sv | 57 +++++
 rtl/cl_mem_responder.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cl_mem_pkg.sv
// Shared defaults and request/response records for the memory responder.
// Struct field widths follow the default parameter set.
package cl_mem_pkg;

  localparam int ADDR_LMT_DEF    = 20;
  localparam int MDATA_DEF       = 14;
  localparam int CACHE_WIDTH_DEF = 512;
  localparam int MEM_AW_DEF      = 6;
  localparam int FIFO_AW_DEF     = 4;
  localparam int AF_SLACK_DEF    = 4;
  localparam int RD_LAT_DEF      = 4;
  localparam int WR_LAT_DEF      = 2;

  typedef struct packed {
    logic [ADDR_LMT_DEF-1:0] addr;
    logic [MDATA_DEF-1:0]    mdata;
  } rd_req_t;

  typedef struct packed {
    logic [ADDR_LMT_DEF-1:0]    addr;
    logic [MDATA_DEF-1:0]       mdata;
    logic [CACHE_WIDTH_DEF-1:0] data;
  } wr_req_t;

  typedef struct packed {
    logic                       valid;
    logic [MDATA_DEF-1:0]       mdata;
    logic [CACHE_WIDTH_DEF-1:0] data;
  } rd_rsp_t;

  // chan selects which write-completion channel carries the response.
  typedef struct packed {
    logic                 valid;
    logic                 chan;
    logic [MDATA_DEF-1:0] mdata;
  } wr_rsp_t;

endpackage

// File: rtl/cl_req_fifo.sv
// Synchronous request FIFO, depth 2^AW, show-ahead read (pop_data is the head).
// Ports: clk, reset (sync, active-high), push/push_data, pop/pop_data,
//        full, empty, count (registered occupancy, 0..2^AW).
// A push on a full FIFO is accepted only when a pop happens in the same
// cycle; a pop on an empty FIFO is ignored, so nothing bypasses the storage.
module cl_req_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] store [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage arrays carry no reset; the pointers alone define validity,
  // and leaving the array out of reset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cl_mem_responder.sv
// Cache-line memory responder model.
// Ports: clk, reset (sync, active-high), stall (freeze FIFO pops);
//   read request  rd_req_en/addr/mdata -> rd_req_almostfull;
//   read response rd_rsp_valid/mdata/data, RD_LAT cycles after pop;
//   write request wr_req_en/addr/mdata/data -> wr_req_almostfull;
//   write completions wr_rsp0_*/wr_rsp1_*, WR_LAT cycles after pop,
//     alternating channels starting at 0;
//   ovf_err (sticky drop flag), rd_served/wr_served (response counters).
module cl_mem_responder
  import cl_mem_pkg::*;
#(
  parameter int ADDR_LMT    = ADDR_LMT_DEF,
  parameter int MDATA       = MDATA_DEF,
  parameter int CACHE_WIDTH = CACHE_WIDTH_DEF,
  parameter int MEM_AW      = MEM_AW_DEF,
  parameter int FIFO_AW     = FIFO_AW_DEF,
  parameter int AF_SLACK    = AF_SLACK_DEF,
  parameter int RD_LAT      = RD_LAT_DEF,
  parameter int WR_LAT      = WR_LAT_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   rd_req_en,
  input  logic [ADDR_LMT-1:0]    rd_req_addr,
  input  logic [MDATA-1:0]       rd_req_mdata,
  output logic                   rd_req_almostfull,
  output logic                   rd_rsp_valid,
  output logic [MDATA-1:0]       rd_rsp_mdata,
  output logic [CACHE_WIDTH-1:0] rd_rsp_data,
  input  logic                   wr_req_en,
  input  logic [ADDR_LMT-1:0]    wr_req_addr,
  input  logic [MDATA-1:0]       wr_req_mdata,
  input  logic [CACHE_WIDTH-1:0] wr_req_data,
  output logic                   wr_req_almostfull,
  output logic                   wr_rsp0_valid,
  output logic [MDATA-1:0]       wr_rsp0_mdata,
  output logic                   wr_rsp1_valid,
  output logic [MDATA-1:0]       wr_rsp1_mdata,
  output logic                   ovf_err,
  output logic [31:0]            rd_served,
  output logic [31:0]            wr_served
);

  localparam int               FIFO_DEPTH = 1 << FIFO_AW;
  localparam int               MEM_LINES  = 1 << MEM_AW;
  localparam logic [FIFO_AW:0] AF_LEVEL   = (FIFO_AW+1)'(FIFO_DEPTH - AF_SLACK);

  rd_req_t          rd_push_data, rd_head;
  wr_req_t          wr_push_data, wr_head;
  logic             rd_full, rd_empty, wr_full, wr_empty;
  logic [FIFO_AW:0] rd_count, wr_count;
  logic             rd_push, wr_push, pop_ok, rd_fire, wr_fire;

  // Requests during reset are ignored, and nothing pops while in reset.
  assign rd_push = rd_req_en & ~reset;
  assign wr_push = wr_req_en & ~reset;
  assign pop_ok  = ~stall & ~reset;
  assign rd_fire = pop_ok & ~rd_empty;
  assign wr_fire = pop_ok & ~wr_empty;

  assign rd_push_data = '{addr: rd_req_addr, mdata: rd_req_mdata};
  assign wr_push_data = '{addr: wr_req_addr, mdata: wr_req_mdata, data: wr_req_data};

  cl_req_fifo #(.DW($bits(rd_req_t)), .AW(FIFO_AW)) u_rd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_push),
    .push_data (rd_push_data),
    .pop       (pop_ok),
    .pop_data  (rd_head),
    .full      (rd_full),
    .empty     (rd_empty),
    .count     (rd_count)
  );

  cl_req_fifo #(.DW($bits(wr_req_t)), .AW(FIFO_AW)) u_wr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_push),
    .push_data (wr_push_data),
    .pop       (pop_ok),
    .pop_data  (wr_head),
    .full      (wr_full),
    .empty     (wr_empty),
    .count     (wr_count)
  );

  // Almostfull is a pure compare on the registered occupancy.
  assign rd_req_almostfull = (rd_count >= AF_LEVEL);
  assign wr_req_almostfull = (wr_count >= AF_LEVEL);

  // Backing store: only the low MEM_AW address bits index it, so higher
  // addresses alias onto the same lines. Contents survive reset.
  logic [CACHE_WIDTH-1:0] mem [MEM_LINES];
  logic [MEM_AW-1:0]      rd_idx, wr_idx;
  logic [CACHE_WIDTH-1:0] rd_line;
  logic                   unused_addr_hi;

  assign rd_idx         = rd_head.addr[MEM_AW-1:0];
  assign wr_idx         = wr_head.addr[MEM_AW-1:0];
  assign unused_addr_hi = ^{rd_head.addr[ADDR_LMT-1:MEM_AW], wr_head.addr[ADDR_LMT-1:MEM_AW]};

  // The read is sampled combinationally in the pop cycle while the write
  // lands at the closing edge, so a same-cycle read sees the old line.
  assign rd_line = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_idx] <= wr_head.data;
  end

  // Fixed-latency response pipelines; the last stage drives the outputs.
  rd_rsp_t rd_pipe [RD_LAT];
  wr_rsp_t wr_pipe [WR_LAT];
  logic    wr_chan;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) rd_pipe[i].valid <= 1'b0;
    end else begin
      rd_pipe[0] <= '{valid: rd_fire, mdata: rd_head.mdata, data: rd_line};
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WR_LAT; i++) wr_pipe[i].valid <= 1'b0;
      wr_chan   <= 1'b0;
      ovf_err   <= 1'b0;
      rd_served <= '0;
      wr_served <= '0;
    end else begin
      wr_pipe[0] <= '{valid: wr_fire, chan: wr_chan, mdata: wr_head.mdata};
      for (int i = 1; i < WR_LAT; i++) wr_pipe[i] <= wr_pipe[i-1];
      if (wr_fire) wr_chan <= ~wr_chan;
      // A push to a full FIFO is only a drop when no pop frees a slot.
      if ((rd_req_en & rd_full & ~rd_fire) | (wr_req_en & wr_full & ~wr_fire))
        ovf_err <= 1'b1;
      if (rd_rsp_valid)                  rd_served <= rd_served + 32'd1;
      if (wr_rsp0_valid | wr_rsp1_valid) wr_served <= wr_served + 32'd1;
    end
  end

  assign rd_rsp_valid  = rd_pipe[RD_LAT-1].valid;
  assign rd_rsp_mdata  = rd_pipe[RD_LAT-1].mdata;
  assign rd_rsp_data   = rd_pipe[RD_LAT-1].data;
  assign wr_rsp0_valid = wr_pipe[WR_LAT-1].valid & ~wr_pipe[WR_LAT-1].chan;
  assign wr_rsp1_valid = wr_pipe[WR_LAT-1].valid &  wr_pipe[WR_LAT-1].chan;
  assign wr_rsp0_mdata = wr_pipe[WR_LAT-1].mdata;
  assign wr_rsp1_mdata = wr_pipe[WR_LAT-1].mdata;

endmodule
